grouped_rr_arbiter: RTL

Registered two-level round-robin arbiter that shares one resource among `N` requesters, split into two groups of `N/2`. Requesters are granted in fair rotation, alternating between groups and rotating within each group. A grant is held until the owner drops its request, or is pre-empted once a hold limit expires while others are waiting. It sits in front of the shared datapath as the fair, stateful counterpart to the team's cascaded fixed-priority arbiter. From reset it grants in the same order as that arbiter: lower group first, lowest index first.

---
 rtl/grouped_rr_arbiter_if.sv | 15 +
 rtl/grouped_rr_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/grouped_rr_arbiter_if.sv
// Request/grant bundle between requesters and the grouped round-robin arbiter.
// The requester side drives req; the arbiter drives the registered grant signals.
interface grouped_rr_arbiter_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;

  modport master (output req, input grant, input grant_valid, input grant_id);
  modport slave  (input req, output grant, output grant_valid, output grant_id);
endinterface

// File: rtl/grouped_rr_arbiter.sv
// Registered two-level round-robin arbiter: alternates between two halves of req,
// rotates within each half, and pre-empts a holder after MAX_HOLD cycles under contention.
module grouped_rr_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  grouped_rr_arbiter_if.slave bus
);
  localparam int L  = N / 2;
  localparam int IW = $clog2(N);
  localparam int LW = $clog2(L);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [LW-1:0] LAST_M   = LW'(L - 1);
  localparam logic [IW-1:0] GRP1_BASE = IW'(L);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic          gptr;
  logic [LW-1:0] lptr0;
  logic [LW-1:0] lptr1;
  logic [IW-1:0] cur;
  logic [HW-1:0] hold_cnt;

  // Returns {found, index}: preferred group if it has any request, else the other,
  // then first set bit at or above that group's pointer, wrapping within the group.
  function automatic logic [IW:0] pick(input logic [N-1:0]  r,
                                       input logic          gp,
                                       input logic [LW-1:0] p0,
                                       input logic [LW-1:0] p1);
    logic          g;
    logic [L-1:0]  bits;
    logic [LW-1:0] p;
    logic [IW:0]   res;
    int            m;
    res  = '0;
    g    = (gp ? |r[N-1:L] : |r[L-1:0]) ? gp : ~gp;
    bits = g ? r[N-1:L] : r[L-1:0];
    p    = g ? p1 : p0;
    for (int i = 0; i < L; i++) begin
      m = int'(p) + i;
      if (m >= L) m = m - L;
      if (!res[IW] && bits[LW'(m)]) res = {1'b1, IW'(m + (g ? L : 0))};
    end
    return res;
  endfunction

  function automatic logic [LW-1:0] next_member(input logic [LW-1:0] m);
    return (m == LAST_M) ? '0 : m + 1'b1;
  endfunction

  logic          cur_g;
  logic [LW-1:0] cur_m;
  logic [LW-1:0] rel_lp0;
  logic [LW-1:0] rel_lp1;
  logic [IW:0]   win_now;
  logic [IW:0]   win_rel;
  logic          others;
  logic          release_now;

  always_comb begin
    cur_g       = (cur >= GRP1_BASE);
    cur_m       = cur_g ? LW'(cur - GRP1_BASE) : LW'(cur);
    rel_lp0     = cur_g ? lptr0 : next_member(cur_m);
    rel_lp1     = cur_g ? next_member(cur_m) : lptr1;
    win_now     = pick(bus.req, gptr, lptr0, lptr1);
    // Re-arbitration on release already sees the rotated pointers.
    win_rel     = pick(bus.req, ~cur_g, rel_lp0, rel_lp1);
    others      = |(bus.req & ~(N'(1) << cur));
    release_now = !bus.req[cur] ||
                  ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && others);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      gptr            <= 1'b0;
      lptr0           <= '0;
      lptr1           <= '0;
      cur             <= '0;
      hold_cnt        <= '0;
      bus.grant       <= '0;
      bus.grant_valid <= 1'b0;
      bus.grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_now[IW]) begin
            state           <= BUSY;
            cur             <= win_now[IW-1:0];
            hold_cnt        <= HW'(1);
            bus.grant       <= N'(1) << win_now[IW-1:0];
            bus.grant_valid <= 1'b1;
            bus.grant_id    <= win_now[IW-1:0];
          end
        end
        BUSY: begin
          if (release_now) begin
            gptr  <= ~cur_g;
            lptr0 <= rel_lp0;
            lptr1 <= rel_lp1;
            if (win_rel[IW]) begin
              cur             <= win_rel[IW-1:0];
              hold_cnt        <= HW'(1);
              bus.grant       <= N'(1) << win_rel[IW-1:0];
              bus.grant_valid <= 1'b1;
              bus.grant_id    <= win_rel[IW-1:0];
            end else begin
              state           <= IDLE;
              hold_cnt        <= '0;
              bus.grant       <= '0;
              bus.grant_valid <= 1'b0;
              bus.grant_id    <= '0;
            end
          end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
